tile_deserializer: RTL and testbench

Serial-to-parallel pixel packer: the inverse of the per-plane 4-bit load/shift pixel serializer used in the tile/sprite output path. It accepts one 4-plane pixel per clock under a valid/ready handshake and assembles PIX pixels per plane into one planar word. Optional horizontal flip mirrors pixel order within the word. Used where rendered pixel streams are written back into planar tile/line RAM format, for example the sprite line buffer writeback and the test pattern capture path.

---
 rtl/gfx_pkg.sv | 17 +
 rtl/tile_deserializer_plane_packer.sv | 45 ++++
 rtl/tile_deserializer.sv | 96 +++++++++
 tb/tb_tile_deserializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared pixel-packing constants and the planar field index helper
// for the tile/sprite write-back path.
package gfx_pkg;

    localparam int unsigned PIX_DEF    = 8;
    localparam int unsigned PLANES_DEF = 4;
    localparam int unsigned WORD_W_DEF = PIX_DEF * PLANES_DEF;

    function automatic int unsigned field_idx(
        input int unsigned plane,
        input int unsigned bitpos,
        input int unsigned pix
    );
        return plane * pix + bitpos;
    endfunction

endpackage

// File: rtl/tile_deserializer_plane_packer.sv
// One bitplane of the deserializer: a PIX-bit assembly register written one bit per
// accepted pixel at a position decoded from the pixel index and the word's flip.
module plane_packer #(
    parameter int unsigned PIX = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    we_i,
    input  logic                    last_i,
    input  logic                    flip_i,
    input  logic [$clog2(PIX)-1:0]  idx_i,
    input  logic                    bit_i,
    output logic [PIX-1:0]          word_o
);

    localparam int unsigned IDXW = $clog2(PIX);

    logic [IDXW-1:0] pos;
    logic [PIX-1:0]  sel;
    logic [PIX-1:0]  word_q;
    logic [PIX-1:0]  word_d;

    // word_o is the register with this cycle's bit merged in, so the top can
    // push a completed word on the same edge its final pixel arrives.
    always_comb begin
        pos      = flip_i ? idx_i : IDXW'(PIX - 1) - idx_i;
        sel      = '0;
        sel[pos] = 1'b1;
        word_o   = clr_i ? '0 : word_q;
        if (we_i) begin
            word_o = (word_o & ~sel) | (bit_i ? sel : '0);
        end
        word_d = (we_i && last_i) ? '0 : word_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/tile_deserializer.sv
// Serial-to-parallel pixel packer: one PLANES-bit pixel per accept, PIX pixels per
// planar output word, buffered through a 2-entry output FIFO.
module tile_deserializer
    import gfx_pkg::*;
#(
    parameter int unsigned PIX    = PIX_DEF,
    parameter int unsigned PLANES = PLANES_DEF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [PLANES-1:0]       SIN,
    input  logic                    SIN_VALID,
    output logic                    SIN_READY,
    input  logic                    FLIP,
    input  logic                    SYNC,
    output logic [PLANES*PIX-1:0]   OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    localparam int unsigned IDXW = $clog2(PIX);
    localparam int unsigned W    = PLANES * PIX;

    logic [IDXW-1:0] idx_q, idx_d, idx_cur;
    logic            flip_q, flip_d, flip_cur;
    logic            accept, last, push, pop;
    logic [W-1:0]    asm_word;
    logic [W-1:0]    fifo_q [2];
    logic            wr_q, rd_q;
    logic [1:0]      cnt_q;

    assign SIN_READY = (cnt_q < 2'd2);
    assign accept    = SIN_VALID & SIN_READY;
    assign OUT_VALID = (cnt_q != 2'd0);
    assign OUT_DATA  = fifo_q[rd_q];
    assign push      = accept & last;
    assign pop       = OUT_VALID & OUT_READY;

    // SYNC forces the current pixel to index 0, so a pixel arriving with SYNC
    // starts the new word and supplies its flip.
    always_comb begin
        idx_cur  = SYNC ? '0 : idx_q;
        flip_cur = (idx_cur == '0) ? FLIP : flip_q;
        last     = (idx_cur == IDXW'(PIX - 1));
        idx_d    = idx_cur;
        flip_d   = flip_q;
        if (accept) begin
            idx_d  = last ? '0 : idx_cur + IDXW'(1);
            flip_d = flip_cur;
        end
    end

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        plane_packer #(
            .PIX (PIX)
        ) u_pack (
            .clk_i  (CLK),
            .rst_i  (RESET),
            .clr_i  (SYNC),
            .we_i   (accept),
            .last_i (last),
            .flip_i (flip_cur),
            .idx_i  (idx_cur),
            .bit_i  (SIN[p]),
            .word_o (asm_word[field_idx(p, 0, PIX) +: PIX])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q     <= '0;
            flip_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            idx_q  <= idx_d;
            flip_q <= flip_d;
            if (push) begin
                fifo_q[wr_q] <= asm_word;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_deserializer.sv
// Directed bench for tile_deserializer at PIX=8, PLANES=4: vector table plus
// hand-written backpressure, streaming, SYNC and reset sequences.
module tb_tile_deserializer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  SIN;
    logic        SIN_VALID;
    logic        SIN_READY;
    logic        FLIP;
    logic        SYNC;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    tile_deserializer #(
        .PIX    (8),
        .PLANES (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SIN       (SIN),
        .SIN_VALID (SIN_VALID),
        .SIN_READY (SIN_READY),
        .FLIP      (FLIP),
        .SYNC      (SYNC),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    // px[i] is pixel i of the word; fl[i] is FLIP while pixel i is offered.
    typedef struct {
        string            name;
        logic [7:0][3:0]  px;
        logic [7:0]       fl;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [3:0] px, input logic fl);
        int n;
        SIN       = px;
        FLIP      = fl;
        SIN_VALID = 1'b1;
        n = 0;
        while (!SIN_READY && n < 100) begin
            tick();
            n++;
        end
        if (!SIN_READY) begin
            total++;
            bad++;
            $display("FAIL put_timeout: SIN_READY stuck at %b, expected 1", SIN_READY);
        end
        tick();
        SIN_VALID = 1'b0;
    endtask

    task automatic send_word(input string nm, input logic [7:0][3:0] px, input logic [7:0] fl);
        for (int i = 0; i < 8; i++) begin
            put(px[i], fl[i]);
            if (i == 6) chk({nm, "_early_valid"}, 32'(OUT_VALID), 32'd0);
        end
    endtask

    task automatic pop_one();
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    initial begin
        int          acc;
        int          drop;
        int          seen;
        int          stalls;
        logic [31:0] q[$];

        vecs[0] = '{"p0_fl0",     32'h00000001, 8'h00, 32'h00000080};
        vecs[1] = '{"p7_plane3",  32'h80000000, 8'h00, 32'h01000000};
        vecs[2] = '{"p0_fl1",     32'h00000001, 8'hFF, 32'h00000001};
        vecs[3] = '{"all_ones",   32'hFFFFFFFF, 8'h00, 32'hFFFFFFFF};
        vecs[4] = '{"walk_fl0",   32'h84218421, 8'h00, 32'h11224488};
        vecs[5] = '{"walk_fl1",   32'h84218421, 8'hFF, 32'h88442211};
        vecs[6] = '{"p3_fl1",     32'h0000F000, 8'hFF, 32'h08080808};
        vecs[7] = '{"p3_fl0",     32'h0000F000, 8'h00, 32'h10101010};
        vecs[8] = '{"fl_drop_p3", 32'h00000001, 8'h07, 32'h00000001};
        vecs[9] = '{"fl_rise_p3", 32'h00000001, 8'hF8, 32'h00000080};

        RESET     = 1'b1;
        SIN       = '0;
        SIN_VALID = 1'b0;
        FLIP      = 1'b0;
        SYNC      = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_data",  OUT_DATA,       32'd0);
        chk("rst_ready", 32'(SIN_READY), 32'd1);

        seen = 0;
        repeat (20) begin
            tick();
            if (OUT_VALID) seen++;
        end
        chk("idle_valid_count", 32'(seen), 32'd0);

        foreach (vecs[k]) begin
            send_word(vecs[k].name, vecs[k].px, vecs[k].fl);
            chk({vecs[k].name, "_valid"}, 32'(OUT_VALID), 32'd1);
            chk({vecs[k].name, "_data"},  OUT_DATA,       vecs[k].exp);
            pop_one();
            chk({vecs[k].name, "_popped"}, 32'(OUT_VALID), 32'd0);
        end

        // Backpressure: 24 back-to-back offers with the consumer stalled.
        acc  = 0;
        drop = -1;
        FLIP = 1'b0;
        for (int c = 0; c < 24; c++) begin
            SIN       = 4'(1 << (acc / 8));
            SIN_VALID = 1'b1;
            if (SIN_READY) acc++;
            else if (drop < 0) drop = c;
            tick();
        end
        SIN_VALID = 1'b0;
        chk("bp_accepted",   32'(acc),  32'd16);
        chk("bp_drop_cycle", 32'(drop), 32'd16);
        chk("bp_head0",      OUT_DATA,  32'h000000FF);
        OUT_READY = 1'b1;
        tick();
        chk("bp_ready_after_pop", 32'(SIN_READY), 32'd1);
        chk("bp_head1",           OUT_DATA,       32'h0000FF00);
        tick();
        OUT_READY = 1'b0;
        chk("bp_drained", 32'(OUT_VALID), 32'd0);
        send_word("bp_third", 32'h44444444, 8'h00);
        chk("bp_third_data", OUT_DATA, 32'h00FF0000);
        pop_one();

        // Sustained streaming with the consumer always ready.
        OUT_READY = 1'b1;
        stalls    = 0;
        for (int c = 0; c < 18; c++) begin
            if (OUT_VALID) q.push_back(OUT_DATA);
            if (c < 16) begin
                if (!SIN_READY) stalls++;
                SIN       = (c < 8) ? 4'h1 : 4'h8;
                SIN_VALID = 1'b1;
            end else begin
                SIN_VALID = 1'b0;
            end
            tick();
        end
        OUT_READY = 1'b0;
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_words",  32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            chk("stream_word0", q[0], 32'h000000FF);
            chk("stream_word1", q[1], 32'hFF000000);
        end

        // SYNC alone after 5 pixels discards them.
        for (int i = 0; i < 5; i++) put(4'hF, 1'b1);
        SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        chk("sync_no_word", 32'(OUT_VALID), 32'd0);
        send_word("sync_a", 32'h84218421, 8'h00);
        chk("sync_a_data", OUT_DATA, 32'h11224488);
        pop_one();
        chk("sync_a_single", 32'(OUT_VALID), 32'd0);

        // SYNC coincident with a pixel: that pixel is index 0 and sets the flip.
        for (int i = 0; i < 3; i++) put(4'hF, 1'b0);
        SYNC = 1'b1;
        put(4'h1, 1'b1);
        SYNC = 1'b0;
        for (int i = 0; i < 7; i++) put(4'h0, 1'b0);
        chk("sync_b_valid", 32'(OUT_VALID), 32'd1);
        chk("sync_b_data",  OUT_DATA,       32'h00000001);
        pop_one();

        // Reset mid-word with a word waiting in the FIFO.
        send_word("rst_pre", 32'h00000001, 8'h00);
        for (int i = 0; i < 3; i++) put(4'hF, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_data",  OUT_DATA,       32'd0);
        chk("midrst_ready", 32'(SIN_READY), 32'd1);
        send_word("rst_post", 32'h84218421, 8'h00);
        chk("rst_post_valid", 32'(OUT_VALID), 32'd1);
        chk("rst_post_data",  OUT_DATA,       32'h11224488);
        pop_one();
        chk("rst_post_single", 32'(OUT_VALID), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
